stage3_sin: RTL and testbench
=============================

Name: stage3_sin

Overview:
- Forward counterpart of the stage-3 arcsine block: given a signed 12-bit angle and a magnitude magMN, computes L = magMN * sin(angle).
- Feeds forward-kinematics / plate-position estimation from commanded servo angles, and closes the loop back to stage-3 (asin) results.
- Iterative rotation-mode CORDIC, one micro-rotation per clock.
- Start is a single-cycle enable pulse; completion is signalled by a one-cycle valid pulse.

Parameters:
- ANGLE_W, 12: angle width. Signed; LSB = pi/2048 rad, full range [-pi, pi).
- MAG_W, 16: unsigned magnitude width.
- ITER, 14: CORDIC micro-rotations, legal range 8..16.
- GUARD, 3: extra fractional bits on the internal x/y datapath.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  start pulse, sampled on the rising edge
- angle  in  ANGLE_W  signed angle (same encoding as the stage-3 asin output)
- magMN  in  MAG_W  unsigned magnitude
- L  out  MAG_W+1  signed result, magMN*sin(angle)
- valid  out  1  one-cycle pulse when L is updated
- busy  out  1  high from the accepted enable until the valid cycle, inclusive

Behaviour:
- Reset (async, rst_n=0): state IDLE; L=0, valid=0, busy=0; x, y, z, iteration counter cleared.
- FSM states:
  - IDLE: enable=1 captures angle and magMN, then goes to LOAD.
  - LOAD: gain pre-compensation and quadrant fold.
    - x0 = (magMN*19899)>>15, with K=0.60725 in Q15; y0 = 0.
    - z0 = angle folded into [-pi/2, pi/2], extended by 4 fractional bits:
      - angle > 1024: use 2048-angle.
      - angle < -1024: use -2048-angle.
      - angle = -2048 gives 0.
  - ROT: counter i = 0..ITER-1.
    - d = sign(z).
    - x -= d*(y>>>i); y += d*(x>>>i), both using pre-update values.
    - z -= d*atan_tab[i].
    - Arithmetic shifts only.
  - DONE: L = round(y >> GUARD), half away from zero. valid=1 for this cycle only, then IDLE.
- Latency: enable sampled at edge 0 gives valid at edge ITER+2 (16 clocks by default). Throughput is one result per ITER+3 cycles.
- enable while busy=1 is ignored; in-flight inputs are unaffected.
- Input changes after capture have no effect.
- L holds its last value between valid pulses.
- Reset mid-operation aborts immediately: no valid pulse, and L=0 after release.
- Internal widths: x,y signed MAG_W+GUARD+2 bits; z signed ANGLE_W+4 bits. No overflow is permitted for any legal input.

Optional Feature:
- SIN_CLAMP_EN defined: DONE saturates L to [-magMN, +magMN]. Guarantees |L| <= magMN, so a forward/inverse chain never presents stage-3 asin with a ratio above 1.
- SIN_CLAMP_EN undefined: raw rounded CORDIC result. |L| may exceed magMN by up to 2 LSB.

Decomposition:
- Package stage3_pkg:
  - ANGLE_W/MAG_W defaults
  - CORDIC gain constant 19899 (Q15)
  - ANGLE_PI = 2048 and ANGLE_HALF_PI = 1024
  - atan table: 16 entries, LSB pi/32768, atan_tab[0] = 8192
  - FSM state encoding
- One sub-module: cordic_rot_step, the combinational single micro-rotation (x, y, z, i -> x', y', z'). The top keeps the FSM, registers and rounding.

Test Plan:
- angle=0, magMN=6087, pulse enable: valid exactly 16 cycles later, L=0, busy high for 17 cycles.
- angle=512 (pi/4), magMN=6087 -> L=4304±2; angle=1536 (3pi/4) -> same 4304±2, checking the fold.
- angle=1024, magMN=6087 -> L in [6085,6087] with SIN_CLAMP_EN (never above 6087); without the macro, [6085,6089].
- angle=-341, magMN=6087 -> L=-3040±2; angle=-2048 -> L=0±1; angle=2047, magMN=65535 -> L=101±2 with no overflow.
- Round trip: L=1166, magMN=6087 through stage-3 asin gives angle 126; feeding angle=126, magMN=6087 here -> L=1169±2.
- Second enable during busy is ignored (single valid). rst_n low mid-ROT: no valid, L=0. A new enable after release completes normally.

Source files
------------

// File: rtl/stage3_pkg.sv
// Shared constants, FSM encoding and arctangent table for the stage-3 sine CORDIC.
package stage3_pkg;
   localparam int ANGLE_W_DEF   = 12;
   localparam int MAG_W_DEF     = 16;
   localparam int ITER_DEF      = 14;
   localparam int GUARD_DEF     = 3;
   localparam int CORDIC_K_Q15  = 19899;
   localparam int ANGLE_PI      = 2048;
   localparam int ANGLE_HALF_PI = 1024;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROT, ST_DONE} state_e;

   // atan(2^-i) in units of pi/32768, i.e. the angle LSB with 4 extra fraction bits
   function automatic logic [13:0] atan_tab(input logic [3:0] i);
      case (i)
         4'd0:    atan_tab = 14'd8192;
         4'd1:    atan_tab = 14'd4836;
         4'd2:    atan_tab = 14'd2555;
         4'd3:    atan_tab = 14'd1297;
         4'd4:    atan_tab = 14'd651;
         4'd5:    atan_tab = 14'd326;
         4'd6:    atan_tab = 14'd163;
         4'd7:    atan_tab = 14'd81;
         4'd8:    atan_tab = 14'd41;
         4'd9:    atan_tab = 14'd20;
         4'd10:   atan_tab = 14'd10;
         4'd11:   atan_tab = 14'd5;
         4'd12:   atan_tab = 14'd3;
         4'd13:   atan_tab = 14'd1;
         4'd14:   atan_tab = 14'd1;
         default: atan_tab = 14'd0;
      endcase
   endfunction
endpackage

// File: rtl/cordic_rot_step.sv
// One combinational rotation-mode CORDIC micro-rotation; direction follows the sign of z.
module cordic_rot_step
   import stage3_pkg::*;
#(
   parameter int XY_W = 21,
   parameter int Z_W  = 16
) (
   input  logic signed [XY_W-1:0] x_in,
   input  logic signed [XY_W-1:0] y_in,
   input  logic signed [Z_W-1:0]  z_in,
   input  logic        [3:0]      i_in,
   output logic signed [XY_W-1:0] x_out,
   output logic signed [XY_W-1:0] y_out,
   output logic signed [Z_W-1:0]  z_out
);
   logic signed [XY_W-1:0] x_sh, y_sh;
   logic signed [Z_W-1:0]  atan_s;

   always_comb begin
      x_sh   = x_in >>> i_in;
      y_sh   = y_in >>> i_in;
      atan_s = Z_W'({1'b0, atan_tab(i_in)});
      if (!z_in[Z_W-1]) begin
         x_out = x_in - y_sh;
         y_out = y_in + x_sh;
         z_out = z_in - atan_s;
      end else begin
         x_out = x_in + y_sh;
         y_out = y_in - x_sh;
         z_out = z_in + atan_s;
      end
   end
endmodule

// File: rtl/stage3_sin.sv
// Iterative CORDIC computing L = magMN*sin(angle), one micro-rotation per clock.
// Define SIN_CLAMP_EN to saturate L to [-magMN, +magMN].
module stage3_sin
   import stage3_pkg::*;
#(
   parameter int ANGLE_W = ANGLE_W_DEF,
   parameter int MAG_W   = MAG_W_DEF,
   parameter int ITER    = ITER_DEF,
   parameter int GUARD   = GUARD_DEF
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic signed [ANGLE_W-1:0] angle,
   input  logic        [MAG_W-1:0]   magMN,
   output logic signed [MAG_W:0]     L,
   output logic                      valid,
   output logic                      busy
);
   localparam int XY_W = MAG_W + GUARD + 2;
   localparam int Z_W  = ANGLE_W + 4;
   localparam int PW   = MAG_W + 15;

   localparam logic signed [ANGLE_W:0] A_PI  = (ANGLE_W+1)'(ANGLE_PI);
   localparam logic signed [ANGLE_W:0] A_HPI = (ANGLE_W+1)'(ANGLE_HALF_PI);
   localparam logic signed [XY_W:0]    RND_HALF = (XY_W+1)'(1 << (GUARD-1));
   localparam logic signed [XY_W:0]    L_MAX = (XY_W+1)'((1 << MAG_W) - 1);
   localparam logic signed [XY_W:0]    L_MIN = -L_MAX - (XY_W+1)'(1);

   state_e                    state_q, state_d;
   logic signed [ANGLE_W-1:0] ang_q, ang_d;
   logic        [MAG_W-1:0]   mag_q, mag_d;
   logic signed [XY_W-1:0]    x_q, x_d, y_q, y_d, x_rot, y_rot;
   logic signed [Z_W-1:0]     z_q, z_d, z_rot;
   logic        [3:0]         i_q, i_d;
   logic signed [MAG_W:0]     l_q, l_d;
   logic                      valid_q, valid_d, busy_q, busy_d;

   logic        [PW-1:0]      prod;
   logic signed [ANGLE_W:0]   ang_x, fold;
   logic signed [XY_W:0]      y_r, l_full, l_sat;
`ifdef SIN_CLAMP_EN
   logic signed [XY_W:0]      lim;
`endif

   cordic_rot_step #(.XY_W(XY_W), .Z_W(Z_W)) u_step (
      .x_in (x_q),
      .y_in (y_q),
      .z_in (z_q),
      .i_in (i_q),
      .x_out(x_rot),
      .y_out(y_rot),
      .z_out(z_rot)
   );

   always_comb begin
      state_d = state_q;
      ang_d   = ang_q;
      mag_d   = mag_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      l_d     = l_q;
      valid_d = 1'b0;
      busy_d  = busy_q;

      // Gain pre-compensation truncates to whole magnitude LSBs, then moves onto the guard grid.
      prod  = PW'(mag_q) * PW'(CORDIC_K_Q15);
      ang_x = {ang_q[ANGLE_W-1], ang_q};
      if (ang_x > A_HPI)       fold = A_PI - ang_x;
      else if (ang_x < -A_HPI) fold = -A_PI - ang_x;
      else                     fold = ang_x;

      y_r    = {y_q[XY_W-1], y_q} + RND_HALF - (XY_W+1)'(y_q[XY_W-1]);
      l_full = y_r >>> GUARD;
`ifdef SIN_CLAMP_EN
      lim = (XY_W+1)'(mag_q);
      if (l_full > lim)       l_sat = lim;
      else if (l_full < -lim) l_sat = -lim;
      else                    l_sat = l_full;
`else
      if (l_full > L_MAX)      l_sat = L_MAX;
      else if (l_full < L_MIN) l_sat = L_MIN;
      else                     l_sat = l_full;
`endif

      case (state_q)
         ST_IDLE: begin
            if (valid_q) busy_d = 1'b0;
            if (enable) begin
               ang_d   = angle;
               mag_d   = magMN;
               busy_d  = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            x_d     = XY_W'((prod >> 15) << GUARD);
            y_d     = '0;
            z_d     = Z_W'({fold, 4'b0000});
            i_d     = '0;
            state_d = ST_ROT;
         end
         ST_ROT: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            i_d = i_q + 4'd1;
            if (i_q == 4'(ITER-1)) state_d = ST_DONE;
         end
         default: begin
            l_d     = (MAG_W+1)'(l_sat);
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ang_q   <= '0;
         mag_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         l_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ang_q   <= ang_d;
         mag_q   <= mag_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         l_q     <= l_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign L     = l_q;
   assign valid = valid_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_stage3_sin.sv
// Directed checks of stage3_sin against hand-computed sine values and timing.
module tb_stage3_sin;
   logic                clock = 1'b0;
   logic                rst_n;
   logic                enable;
   logic signed [11:0]  angle;
   logic        [15:0]  magMN;
   logic signed [16:0]  L;
   logic                valid;
   logic                busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   stage3_sin dut (
      .clock (clock),
      .rst_n (rst_n),
      .enable(enable),
      .angle (angle),
      .magMN (magMN),
      .L     (L),
      .valid (valid),
      .busy  (busy)
   );

   task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
      n_chk++;
      if (got < exp - tol || got > exp + tol)
         $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
      else
         n_pass++;
   endtask

   // Pulse enable, then sample each negedge; k counts rising edges after the sampling edge.
   task automatic run_op(input logic signed [11:0] a, input logic [15:0] m,
                         output logic signed [16:0] res, output int lat, output int bcnt);
      @(negedge clock);
      angle  = a;
      magMN  = m;
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      lat    = -1;
      bcnt   = 0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         if (k > 0) @(negedge clock);
         if (busy) bcnt++;
         if (valid) lat = k;
      end
      res = L;
   endtask

   task automatic run_chk(input string tag, input logic signed [11:0] a, input logic [15:0] m,
                          input int exp, input int tol);
      logic signed [16:0] res;
      int lat, bc;
      run_op(a, m, res, lat, bc);
      chk({tag, "_lat"}, lat, 16, 0);
      chk(tag, res, exp, tol);
   endtask

   initial begin
      logic signed [16:0] res;
      logic signed [16:0] seen;
      int lat, bc, nv;

      rst_n  = 1'b0;
      enable = 1'b0;
      angle  = '0;
      magMN  = '0;
      #12;
      chk("rst_L", L, 0, 0);
      chk("rst_valid", valid, 0, 0);
      chk("rst_busy", busy, 0, 0);
      @(negedge clock);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);

      run_op(12'sd0, 16'd6087, res, lat, bc);
      chk("zero_lat", lat, 16, 0);
      chk("zero_busy_cycles", bc, 17, 0);
      chk("zero_L", res, 0, 0);
      @(negedge clock);
      chk("zero_busy_after", busy, 0, 0);
      chk("zero_valid_after", valid, 0, 0);

      run_chk("pi4", 12'sd512, 16'd6087, 4304, 2);
      run_chk("3pi4_fold", 12'sd1536, 16'd6087, 4304, 2);
`ifdef SIN_CLAMP_EN
      run_chk("half_pi", 12'sd1024, 16'd6087, 6086, 1);
`else
      run_chk("half_pi", 12'sd1024, 16'd6087, 6087, 2);
`endif
      run_chk("neg341", -12'sd341, 16'd6087, -3040, 2);
      run_chk("neg_pi", -12'sd2048, 16'd6087, 0, 1);
      run_chk("a2047_max", 12'sd2047, 16'd65535, 101, 2);
      run_chk("roundtrip", 12'sd126, 16'd6087, 1169, 2);
      repeat (5) @(negedge clock);
      chk("hold_L", L, 1169, 2);

      // Second enable and input changes while busy must not disturb the running op.
      @(negedge clock);
      angle  = 12'sd512;
      magMN  = 16'd6087;
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      repeat (4) @(negedge clock);
      angle  = -12'sd341;
      magMN  = 16'd100;
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      nv   = 0;
      seen = '0;
      for (int k = 0; k < 40; k++) begin
         if (valid) begin
            nv++;
            seen = L;
         end
         @(negedge clock);
      end
      chk("busy_ign_nvalid", nv, 1, 0);
      chk("busy_ign_L", seen, 4304, 2);

      // Reset in the middle of the rotation phase.
      @(negedge clock);
      angle  = 12'sd1024;
      magMN  = 16'd6087;
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      repeat (5) @(negedge clock);
      rst_n = 1'b0;
      #1;
      chk("midrst_L", L, 0, 0);
      chk("midrst_busy", busy, 0, 0);
      chk("midrst_valid", valid, 0, 0);
      @(negedge clock);
      rst_n = 1'b1;
      nv = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clock);
         if (valid) nv++;
      end
      chk("midrst_nvalid", nv, 0, 0);
      chk("midrst_L_after", L, 0, 0);
      run_chk("after_rst", -12'sd341, 16'd6087, -3040, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
